// File: rtl/writeback_arbiter.sv
// Writeback arbiter: maps ALU lane 0/1 results and buffered LSU loads onto the two
// register-file write ports, stalling issue when loads have waited too long.
module writeback_arbiter #(
    parameter int D_WIDTH    = 32,
    parameter int LSU_DEPTH  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_alu0_valid,
    input  logic [3:0]         i_alu0_addr,
    input  logic [D_WIDTH-1:0] i_alu0_data,
    input  logic               i_alu1_valid,
    input  logic [3:0]         i_alu1_addr,
    input  logic [D_WIDTH-1:0] i_alu1_data,
    input  logic               i_lsu_valid,
    input  logic [3:0]         i_lsu_addr,
    input  logic [D_WIDTH-1:0] i_lsu_data,
    output logic               o_lsu_ready,
    output logic               o_stall,
    output logic               o_WE1,
    output logic               o_WE2,
    output logic [3:0]         o_WA1,
    output logic [3:0]         o_WA2,
    output logic [D_WIDTH-1:0] o_WD1,
    output logic [D_WIDTH-1:0] o_WD2
);

    localparam int PTR_W = $clog2(LSU_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t             state;
    logic [SW-1:0]      starve, starve_n;
    logic [3:0]         fifo_addr [LSU_DEPTH];
    logic [D_WIDTH-1:0] fifo_data [LSU_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr1;
    logic [CNT_W-1:0]   count, count_next;
    logic               alu0_ok, alu1_ok, push;
    logic [1:0]         free_ports, pops;
    logic               p1_we, p2_we;
    logic [3:0]         p1_addr, p2_addr;
    logic [D_WIDTH-1:0] p1_data, p2_data;

    // Writes to the PC (r15) never reach a port or the FIFO.
    always_comb begin
        alu0_ok     = i_alu0_valid && (i_alu0_addr != 4'hF);
        alu1_ok     = i_alu1_valid && (i_alu1_addr != 4'hF);
        o_lsu_ready = (count != CNT_W'(LSU_DEPTH));
        push        = i_lsu_valid && o_lsu_ready && (i_lsu_addr != 4'hF);
        free_ports  = 2'd2 - {1'b0, alu0_ok} - {1'b0, alu1_ok};
        pops        = (count >= CNT_W'(free_ports)) ? free_ports : count[1:0];
        rd_ptr1     = rd_ptr + PTR_W'(1);
        count_next  = count + CNT_W'(push) - CNT_W'(pops);
        starve_n    = (pops == 2'd0) ? starve + SW'(1) : '0;
    end

    always_comb begin
        p1_we   = 1'b0;
        p1_addr = '0;
        p1_data = '0;
        p2_we   = 1'b0;
        p2_addr = '0;
        p2_data = '0;
        if (alu0_ok) begin
            p1_we   = 1'b1;
            p1_addr = i_alu0_addr;
            p1_data = i_alu0_data;
            if (alu1_ok) begin
                p2_we   = 1'b1;
                p2_addr = i_alu1_addr;
                p2_data = i_alu1_data;
            end
        end else if (alu1_ok) begin
            p1_we   = 1'b1;
            p1_addr = i_alu1_addr;
            p1_data = i_alu1_data;
        end
        if (pops != 2'd0) begin
            if (!alu0_ok && !alu1_ok) begin
                p1_we   = 1'b1;
                p1_addr = fifo_addr[rd_ptr];
                p1_data = fifo_data[rd_ptr];
                if (pops == 2'd2) begin
                    p2_we   = 1'b1;
                    p2_addr = fifo_addr[rd_ptr1];
                    p2_data = fifo_data[rd_ptr1];
                end
            end else begin
                p2_we   = 1'b1;
                p2_addr = fifo_addr[rd_ptr];
                p2_data = fifo_data[rd_ptr];
            end
        end
        // The younger write supersedes the older one to the same register.
        if (p1_we && p2_we && (p1_addr == p2_addr)) begin
            p1_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_WE1 <= 1'b0;
            o_WA1 <= '0;
            o_WD1 <= '0;
            o_WE2 <= 1'b0;
            o_WA2 <= '0;
            o_WD2 <= '0;
        end else begin
            o_WE1 <= p1_we;
            o_WA1 <= p1_addr;
            o_WD1 <= p1_data;
            o_WE2 <= p2_we;
            o_WA2 <= p2_addr;
            o_WD2 <= p2_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pops);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_lsu_addr;
            fifo_data[wr_ptr] <= i_lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            starve  <= '0;
            o_stall <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    starve  <= '0;
                    o_stall <= 1'b0;
                    if (push) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if ((count == CNT_W'(pops)) && !push) begin
                        state   <= IDLE;
                        starve  <= '0;
                        o_stall <= 1'b0;
                    end else begin
                        starve <= starve_n;
                        if ((starve_n == SW'(STARVE_MAX)) || (count_next == CNT_W'(LSU_DEPTH))) begin
                            state   <= FORCE;
                            o_stall <= 1'b1;
                        end else begin
                            o_stall <= 1'b0;
                        end
                    end
                end
                FORCE: begin
                    if (count_next == '0) begin
                        state   <= IDLE;
                        starve  <= '0;
                        o_stall <= 1'b0;
                    end else begin
                        o_stall <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    starve  <= '0;
                    o_stall <= 1'b0;
                end
            endcase
        end
    end

    // Issue must honour the stall; an ALU result during FORCE is a protocol error.
    assert property (@(posedge clk) disable iff (!rst_n) o_stall |-> !(i_alu0_valid || i_alu1_valid));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter: hand-computed port, stall and
// ready values checked with immediate assertions.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_alu0_valid, i_alu1_valid, i_lsu_valid;
    logic [3:0]  i_alu0_addr, i_alu1_addr, i_lsu_addr;
    logic [31:0] i_alu0_data, i_alu1_data, i_lsu_data;
    logic        o_lsu_ready, o_stall, o_WE1, o_WE2;
    logic [3:0]  o_WA1, o_WA2;
    logic [31:0] o_WD1, o_WD2;

    int compared   = 0;
    int mismatched = 0;

    writeback_arbiter #(.D_WIDTH(32), .LSU_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alu0_valid (i_alu0_valid),
        .i_alu0_addr  (i_alu0_addr),
        .i_alu0_data  (i_alu0_data),
        .i_alu1_valid (i_alu1_valid),
        .i_alu1_addr  (i_alu1_addr),
        .i_alu1_data  (i_alu1_data),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_data   (i_lsu_data),
        .o_lsu_ready  (o_lsu_ready),
        .o_stall      (o_stall),
        .o_WE1        (o_WE1),
        .o_WE2        (o_WE2),
        .o_WA1        (o_WA1),
        .o_WA2        (o_WA2),
        .o_WD1        (o_WD1),
        .o_WD2        (o_WD2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic a0v, input logic [3:0] a0a, input logic [31:0] a0d,
                                 input logic a1v, input logic [3:0] a1a, input logic [31:0] a1d,
                                 input logic lv, input logic [3:0] la, input logic [31:0] ld);
        i_alu0_valid = a0v;
        i_alu0_addr  = a0a;
        i_alu0_data  = a0d;
        i_alu1_valid = a1v;
        i_alu1_addr  = a1a;
        i_alu1_data  = a1d;
        i_lsu_valid  = lv;
        i_lsu_addr   = la;
        i_lsu_data   = ld;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        checkOutput("rst_we1", 32'(o_WE1), 32'd0);
        checkOutput("rst_we2", 32'(o_WE2), 32'd0);
        checkOutput("rst_wa1", 32'(o_WA1), 32'd0);
        checkOutput("rst_wd2", o_WD2, 32'd0);
        checkOutput("rst_stall", 32'(o_stall), 32'd0);
        checkOutput("rst_ready", 32'(o_lsu_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Two ALU results map lane 0 -> port 1, lane 1 -> port 2.
        applyStimulus(1'b1, 4'd3, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("t1_we1", 32'(o_WE1), 32'd1);
        checkOutput("t1_wa1", 32'(o_WA1), 32'd3);
        checkOutput("t1_wd1", o_WD1, 32'h11);
        checkOutput("t1_we2", 32'(o_WE2), 32'd1);
        checkOutput("t1_wa2", 32'(o_WA2), 32'd5);
        checkOutput("t1_wd2", o_WD2, 32'h22);

        applyStimulus(1'b1, 4'd4, 32'hA, 1'b1, 4'd4, 32'hB, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("t2_we1", 32'(o_WE1), 32'd0);
        checkOutput("t2_we2", 32'(o_WE2), 32'd1);
        checkOutput("t2_wa2", 32'(o_WA2), 32'd4);
        checkOutput("t2_wd2", o_WD2, 32'hB);

        // Single load with idle ALUs: two-cycle latency.
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'd7, 32'h77);
        tick();
        checkOutput("t3_we1_early", 32'(o_WE1), 32'd0);
        idle();
        tick();
        checkOutput("t3_we1", 32'(o_WE1), 32'd1);
        checkOutput("t3_wa1", 32'(o_WA1), 32'd7);
        checkOutput("t3_wd1", o_WD1, 32'h77);
        checkOutput("t3_we2", 32'(o_WE2), 32'd0);
        checkOutput("t3_stall", 32'(o_stall), 32'd0);
        tick();
        checkOutput("t3_no_dup", 32'(o_WE1), 32'd0);
        checkOutput("t3_ready", 32'(o_lsu_ready), 32'd1);

        // Fill the FIFO while both ALUs hold the ports.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd1, 32'h100 + 32'(i), 1'b1, 4'd2, 32'h200 + 32'(i),
                          1'b1, 4'(8 + i), 32'h80 + 32'(i));
            tick();
            if (i < 3) begin
                checkOutput($sformatf("t4_ready_%0d", i), 32'(o_lsu_ready), 32'd1);
                checkOutput($sformatf("t4_stall_%0d", i), 32'(o_stall), 32'd0);
            end
        end
        checkOutput("t4_full_ready", 32'(o_lsu_ready), 32'd0);
        checkOutput("t4_full_stall", 32'(o_stall), 32'd1);
        checkOutput("t4_alu_wd1", o_WD1, 32'h103);
        idle();
        tick();
        checkOutput("t4_d0_wa1", 32'(o_WA1), 32'd8);
        checkOutput("t4_d0_wd1", o_WD1, 32'h80);
        checkOutput("t4_d0_wa2", 32'(o_WA2), 32'd9);
        checkOutput("t4_d0_wd2", o_WD2, 32'h81);
        checkOutput("t4_d0_we2", 32'(o_WE2), 32'd1);
        checkOutput("t4_d0_stall", 32'(o_stall), 32'd1);
        checkOutput("t4_d0_ready", 32'(o_lsu_ready), 32'd1);
        tick();
        checkOutput("t4_d1_wa1", 32'(o_WA1), 32'd10);
        checkOutput("t4_d1_wd1", o_WD1, 32'h82);
        checkOutput("t4_d1_wa2", 32'(o_WA2), 32'd11);
        checkOutput("t4_d1_wd2", o_WD2, 32'h83);
        checkOutput("t4_d1_stall", 32'(o_stall), 32'd0);
        tick();
        checkOutput("t4_empty_we1", 32'(o_WE1), 32'd0);

        // One load starved by busy ALUs until the forced drain.
        applyStimulus(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b1, 4'd6, 32'h66);
        tick();
        checkOutput("t5_stall_c0", 32'(o_stall), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b0, 4'h0, 32'h0);
            tick();
            checkOutput($sformatf("t5_stall_c%0d", i), 32'(o_stall), (i == 3) ? 32'd1 : 32'd0);
        end
        idle();
        tick();
        checkOutput("t5_we1", 32'(o_WE1), 32'd1);
        checkOutput("t5_wa1", 32'(o_WA1), 32'd6);
        checkOutput("t5_wd1", o_WD1, 32'h66);
        checkOutput("t5_we2", 32'(o_WE2), 32'd0);
        checkOutput("t5_stall_clr", 32'(o_stall), 32'd0);

        // One ALU plus a buffered load share the ports.
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'd12, 32'hC0);
        tick();
        applyStimulus(1'b1, 4'd13, 32'hD0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("mix_wa1", 32'(o_WA1), 32'd13);
        checkOutput("mix_wd1", o_WD1, 32'hD0);
        checkOutput("mix_wa2", 32'(o_WA2), 32'd12);
        checkOutput("mix_wd2", o_WD2, 32'hC0);

        // PC writes are discarded.
        applyStimulus(1'b1, 4'hF, 32'h55, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("t6_pc_we1", 32'(o_WE1), 32'd0);
        checkOutput("t6_pc_we2", 32'(o_WE2), 32'd0);
        applyStimulus(1'b1, 4'hF, 32'h55, 1'b1, 4'd9, 32'h99, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("t6_pc_wa1", 32'(o_WA1), 32'd9);
        checkOutput("t6_pc_we2b", 32'(o_WE2), 32'd0);

        // Asynchronous reset with three loads buffered.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b1, 4'(3 + i), 32'hE0 + 32'(i));
            tick();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_we1", 32'(o_WE1), 32'd0);
        checkOutput("t6_rst_we2", 32'(o_WE2), 32'd0);
        checkOutput("t6_rst_ready", 32'(o_lsu_ready), 32'd1);
        checkOutput("t6_rst_stall", 32'(o_stall), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t6_post_we1_%0d", i), 32'(o_WE1), 32'd0);
            checkOutput($sformatf("t6_post_we2_%0d", i), 32'(o_WE2), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
